// File: rtl/rect_painter.sv
// rtl/rect_painter.sv - command-queue driven rectangle rasteriser
// Drains 3-word draw commands from a circular PRAM queue and emits one frame-buffer write per clock.
module rect_painter #(
  parameter int H_RES   = 160,
  parameter int V_RES   = 120,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 3,
  parameter int PTR_W   = 10,
  parameter int ADDR_W  = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PTR_W-1:0]   wrtPtr,
  input  logic [15:0]        PRAM,
  output logic [PTR_W-1:0]   rdPtr,
  output logic               full,
  output logic [ADDR_W-1:0]  addr,
  output logic [COLOR_W-1:0] data,
  output logic               we,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_SETUP,
    S_PAINT
  } state_t;

  localparam logic [X_W-1:0]    X_MAX    = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]    Y_MAX    = Y_W'(V_RES - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               full_q, full_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               we_q, we_d;
  logic               busy_q, busy_d;
  logic [1:0]         mode_q, mode_d;
  logic [X_W-1:0]     x0_q, x0_d, x1_q, x1_d, x_q, x_d;
  logic [Y_W-1:0]     y0_q, y0_d, y1_q, y1_d, y_q, y_d;

  logic               empty;
  logic               last_pix;
  logic [PTR_W-1:0]   wr_next;
  logic [X_W-1:0]     x0_c, x1_c, x_lo, x_hi;
  logic [Y_W-1:0]     y0_c, y1_c, y_lo, y_hi;
  logic [ADDR_W-1:0]  setup_base;

  assign empty    = (wrtPtr == rd_ptr_q);
  assign wr_next  = wrtPtr + PTR_ONE;
  assign last_pix = (x_q == x1_q) && (y_q == y1_q);

  // Clip, sort and mode-shape the latched coordinates; only consumed in SETUP.
  always_comb begin
    x0_c = (x0_q > X_MAX) ? X_MAX : x0_q;
    x1_c = (x1_q > X_MAX) ? X_MAX : x1_q;
    y0_c = (y0_q > Y_MAX) ? Y_MAX : y0_q;
    y1_c = (y1_q > Y_MAX) ? Y_MAX : y1_q;
    x_lo = (x0_c <= x1_c) ? x0_c : x1_c;
    x_hi = (x0_c <= x1_c) ? x1_c : x0_c;
    y_lo = (y0_c <= y1_c) ? y0_c : y1_c;
    y_hi = (y0_c <= y1_c) ? y1_c : y0_c;
    case (mode_q)
      2'd0: y_hi = y_lo;
      2'd1: x_hi = x_lo;
      2'd3: begin
        x_lo = '0;
        x_hi = X_MAX;
        y_lo = '0;
        y_hi = Y_MAX;
      end
      default: ;
    endcase
    setup_base = ADDR_W'(int'(y_lo) * H_RES);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH0;
      rd_ptr_q   <= '0;
      full_q     <= 1'b0;
      addr_q     <= '0;
      row_base_q <= '0;
      data_q     <= '0;
      color_q    <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      mode_q     <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      x_q        <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      full_q     <= full_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      data_q     <= data_d;
      color_q    <= color_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      mode_q     <= mode_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      x_q        <= x_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      y_q        <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH0: if (!empty) state_d = S_FETCH1;
      S_FETCH1: if (!empty) state_d = S_FETCH2;
      S_FETCH2: if (!empty) state_d = S_SETUP;
      S_SETUP:  state_d = S_PAINT;
      S_PAINT:  if (last_pix) state_d = S_FETCH0;
      default:  state_d = S_FETCH0;
    endcase
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    full_d     = (wr_next == rd_ptr_q);
    addr_d     = addr_q;
    row_base_d = row_base_q;
    data_d     = data_q;
    color_d    = color_q;
    we_d       = 1'b0;
    busy_d     = busy_q;
    mode_d     = mode_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    x_d        = x_q;
    y0_d       = y0_q;
    y1_d       = y1_q;
    y_d        = y_q;
    case (state_q)
      S_FETCH0: begin
        if (!empty) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          busy_d   = 1'b1;
          mode_d   = PRAM[15:14];
          color_d  = PRAM[COLOR_W-1:0];
        end
      end
      S_FETCH1: begin
        if (!empty) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          x0_d     = PRAM[8 +: X_W];
          x1_d     = PRAM[0 +: X_W];
        end
      end
      S_FETCH2: begin
        if (!empty) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          y0_d     = PRAM[8 +: Y_W];
          y1_d     = PRAM[0 +: Y_W];
        end
      end
      S_SETUP: begin
        x0_d       = x_lo;
        x1_d       = x_hi;
        y1_d       = y_hi;
        x_d        = x_lo;
        y_d        = y_lo;
        row_base_d = setup_base;
        addr_d     = setup_base + ADDR_W'(x_lo);
        data_d     = color_q;
        we_d       = 1'b1;
      end
      S_PAINT: begin
        if (last_pix) begin
          busy_d = 1'b0;
        end else begin
          we_d = 1'b1;
          // Row wrap reuses the running base so PAINT needs only adders.
          if (x_q == x1_q) begin
            x_d        = x0_q;
            y_d        = y_q + Y_W'(1);
            row_base_d = row_base_q + ROW_STEP;
            addr_d     = row_base_q + ROW_STEP + ADDR_W'(x0_q);
          end else begin
            x_d    = x_q + X_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign rdPtr = rd_ptr_q;
  assign full  = full_q;
  assign addr  = addr_q;
  assign data  = data_q;
  assign we    = we_q;
  assign busy  = busy_q;

endmodule
